// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared mode constants and chunk sizing for the pipelined adder
package adder_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    function automatic int chunk_w(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/adder_pipe_if.sv
// rtl/adder_pipe_if.sv - operand/result handshake bundle between source, adder_pipe and sink
interface adder_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, s, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, s, cout, ovf
    );
endinterface

// File: rtl/adder_pipe_rca_chunk.sv
// rtl/adder_pipe_rca_chunk.sv - combinational W-bit ripple-carry slice, also exposes carry into its MSB
module rca_chunk #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         c_msb_in
);
    logic [W:0] w_c;

    always_comb begin
        w_c    = '0;
        s      = '0;
        w_c[0] = ci;
        for (int i = 0; i < W; i++) begin
            s[i]     = a[i] ^ b[i] ^ w_c[i];
            w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
        end
    end

    assign co       = w_c[W];
    assign c_msb_in = w_c[W-1];
endmodule

// File: rtl/adder_pipe.sv
// rtl/adder_pipe.sv - pipelined add/sub, one CHUNK-bit slice resolved per stage, global-stall handshake
// Optional build macro: ADDER_PIPE_SAT_EN (saturate s on signed overflow in the last stage)
module adder_pipe
    import adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic        clk,
    input  logic        rst,
    adder_pipe_if.slave bus
);
    localparam int CHUNK = chunk_w(WIDTH, STAGES);

    if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_bad_cfg
        $error("adder_pipe: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
    end

    logic             w_vld_q [STAGES];
    logic [WIDTH-1:0] w_a_q   [STAGES];
    logic [WIDTH-1:0] w_b_q   [STAGES];
    logic [WIDTH-1:0] w_s_q   [STAGES];
    logic             w_c_q   [STAGES];
    logic             w_o_q   [STAGES];
    logic             w_adv;

    // The whole pipe moves together; only a blocked result can stop it
    assign w_adv         = ~w_vld_q[STAGES-1] | bus.out_ready;
    assign bus.in_ready  = w_adv;
    assign bus.out_valid = w_vld_q[STAGES-1];
    assign bus.s         = w_s_q[STAGES-1];
    assign bus.cout      = w_c_q[STAGES-1];
    assign bus.ovf       = w_o_q[STAGES-1];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             w_vld_d;
        logic [WIDTH-1:0] w_a_d;
        logic [WIDTH-1:0] w_b_d;
        logic [WIDTH-1:0] w_s_in;
        logic [WIDTH-1:0] w_s_d;
        logic             w_ci;
        logic             w_co;
        logic             w_cm;
        logic             w_ovf_d;
        logic [CHUNK-1:0] w_cs;

        logic             r_vld;
        logic [WIDTH-1:0] r_a;
        logic [WIDTH-1:0] r_b;
        logic [WIDTH-1:0] r_s;
        logic             r_c;
        logic             r_ovf;

        // Subtraction folds into the head: invert b once and force the first carry
        if (k == 0) begin : g_head
            assign w_vld_d = bus.in_valid;
            assign w_a_d   = bus.a;
            assign w_b_d   = (bus.sub == MODE_SUB) ? ~bus.b : bus.b;
            assign w_ci    = (bus.sub == MODE_SUB) ? 1'b1 : bus.cin;
            assign w_s_in  = '0;
        end else begin : g_body
            assign w_vld_d = w_vld_q[k-1];
            assign w_a_d   = w_a_q[k-1];
            assign w_b_d   = w_b_q[k-1];
            assign w_ci    = w_c_q[k-1];
            assign w_s_in  = w_s_q[k-1];
        end

        rca_chunk #(
            .W (CHUNK)
        ) u_rca (
            .a        (w_a_d[k*CHUNK +: CHUNK]),
            .b        (w_b_d[k*CHUNK +: CHUNK]),
            .ci       (w_ci),
            .s        (w_cs),
            .co       (w_co),
            .c_msb_in (w_cm)
        );

        // Only meaningful in the last stage, where the slice MSB is the word MSB
        assign w_ovf_d = w_cm ^ w_co;

        always_comb begin
            w_s_d                   = w_s_in;
            w_s_d[k*CHUNK +: CHUNK] = w_cs;
`ifdef ADDER_PIPE_SAT_EN
            if ((k == STAGES - 1) && w_ovf_d) begin
                w_s_d = w_a_d[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            end
`endif
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_vld <= 1'b0;
                r_a   <= '0;
                r_b   <= '0;
                r_s   <= '0;
                r_c   <= 1'b0;
                r_ovf <= 1'b0;
            end else if (w_adv) begin
                r_vld <= w_vld_d;
                r_a   <= w_a_d;
                r_b   <= w_b_d;
                r_s   <= w_s_d;
                r_c   <= w_co;
                r_ovf <= w_ovf_d;
            end
        end

        assign w_vld_q[k] = r_vld;
        assign w_a_q[k]   = r_a;
        assign w_b_q[k]   = r_b;
        assign w_s_q[k]   = r_s;
        assign w_c_q[k]   = r_c;
        assign w_o_q[k]   = r_ovf;
    end
endmodule
